simplez_tx_arbiter: RTL and testbench
=====================================

# simplez_tx_arbiter

Round-robin arbiter sharing the single serial transmitter of the Simplez SoC between two byte producers: port 0 (CPU output port writes) and port 1 (debug/trace message generator). It sits between the requesters and the `uart_tx` instance. It sequences each byte through the transmitter's start/ready handshake, guarantees one byte in flight at a time, and flags a transmitter that never acknowledges a start.

## Interface
Parameters:
- `START_TIMEOUT`, default 16: cycles to wait for `tx_ready` to fall after `tx_start` before declaring an error (valid range 2..255).

Ports:
- `clk` in 1: system clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0` in 1: port 0 requests to send `data0`; held high until `ack0`.
- `data0` in 8: port 0 byte; stable while `req0` is high.
- `ack0` out 1: one-cycle pulse; port 0 byte handed to the transmitter.
- `req1` in 1: as `req0`, for port 1.
- `data1` in 8: as `data0`, for port 1.
- `ack1` out 1: as `ack0`, for port 1.
- `lock0` in 1: port 0 requests to keep ownership after its current byte (active only with `TXARB_LOCK_EN`).
- `lock1` in 1: as `lock0`, for port 1.
- `tx_ready` in 1: from `uart_tx`; high = idle.
- `tx_start` out 1: one-cycle start pulse to `uart_tx`.
- `tx_data` out 8: registered byte to `uart_tx`.
- `grant` out 2: one-hot current owner; 00 when idle.
- `err` out 1: sticky timeout flag.

## Operation
The arbiter is a state machine with four states: IDLE, START, WAIT_LOW and WAIT_HIGH.
- **IDLE:** when `tx_ready`=1 and any `reqN`=1, select a winner and go to START.
  - The winner is the single requester if only one requests.
  - If both request, the winner is the port not served last, tracked by the round-robin pointer `last`.
  - On the same edge: `tx_data` ← winner's data; `grant` ← winner one-hot.
- **START:** `tx_start`=1 and `ackN`=1 for the granted port, both for exactly this cycle. Clear the timeout counter; go to WAIT_LOW.
- **WAIT_LOW:**
  - `tx_ready`=0: go to WAIT_HIGH.
  - Otherwise increment the counter. When the counter reaches `START_TIMEOUT`: set `err`, clear `grant`, go to IDLE. `last` is not updated.
- **WAIT_HIGH:** when `tx_ready`=1, set `last` ← owner, clear `grant` (unless locked, see Configuration), and go to IDLE.
- **Data and request sampling:** the byte is captured at the IDLE→START edge. Changes to `dataN` afterwards have no effect. A `reqN` still high after `ackN` is a new request for the next byte.
- **`err`:** set only by a timeout; cleared only by `rst`.
- **`tx_data`:** holds its last value between transfers.
- **Counter:** 8-bit; compared with equality against `START_TIMEOUT`.

## Timing
- **Reset values:** `tx_start`=0, `tx_data`=8'h00, `ack0`=`ack1`=0, `grant`=00, `err`=0, state IDLE, `last`=1 (so port 0 wins the first tie).
- **Latency:** request seen in IDLE with `tx_ready`=1 at edge k → `tx_start`/`ackN` high during cycle k+1.
- **Back-to-back:** `tx_ready` rising at edge m → IDLE after m; the next `tx_start` comes at the earliest 2 cycles after the `tx_ready` rise.
- **`tx_ready` low in IDLE:** requests wait; no grant is made.
- **Request withdrawn in IDLE:** a request dropped before selection is ignored. Dropping it after selection is a protocol violation; the byte is sent anyway.
- **Reset mid-operation:** all outputs return to reset values immediately (asynchronously), and any `tx_start` pulse is truncated.

## Configuration
- **`TXARB_LOCK_EN` defined:** ownership can be held by the current owner.
  - On WAIT_HIGH→IDLE, if the owner's `lockN`=1, `grant` is kept.
  - In IDLE with a kept grant, only the owner's request is considered.
  - Dropping `lockN` in IDLE clears `grant` and restores round-robin from that cycle.
  - Timeout releases the lock.
- **`TXARB_LOCK_EN` undefined:** `lock0`/`lock1` are ignored (ports kept, logic absent); pure round-robin.

## Test plan
- **Single request:** `req0`=1, `data0`=8'h41, `tx_ready`=1 → `tx_start`/`ack0` pulse one cycle later, `tx_data`=8'h41, `grant`=01.
- **Simultaneous requests after reset:** `req0`=`req1`=1 continuously (8'h10 / 8'h20), transmitter model busy 10 cycles per byte → `tx_data` sequence 10,20,10,20; `ack` pulses alternate.
- **Transmitter busy:** `tx_ready`=0 held 30 cycles while `req1`=1 → no `tx_start`. Release → `tx_start` one cycle after `tx_ready` is seen high.
- **Dead transmitter:** `tx_ready` stays 1 after start, `START_TIMEOUT`=16 → `err`=1, 17 cycles after `tx_start`, `grant`=00. `err` stays 1 until `rst`.
- **Lock (`TXARB_LOCK_EN`):** `lock1`=1 with `req1` for 3 bytes while `req0`=1 → 3 consecutive port-1 bytes, then port 0 after `lock1` drops.
- **Async reset during WAIT_HIGH:** `rst` pulse → `grant`=00, `tx_start`=0 immediately. The next tie after reset goes to port 0.

Source files
------------

// File: rtl/simplez_tx_arbiter.sv
// simplez_tx_arbiter: round-robin sharing of the Simplez uart_tx between two byte producers; TXARB_LOCK_EN lets the owner hold the grant
module simplez_tx_arbiter #(
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  input  logic       lock0,
  input  logic       lock1,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [1:0] grant,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, START, WAIT_LOW, WAIT_HIGH} state_t;
  localparam logic [7:0] TIMEOUT = 8'(START_TIMEOUT);
  state_t state_q, state_d;
  logic [1:0] grant_q, grant_d, elig;
  logic [7:0] tx_data_q, tx_data_d, cnt_q, cnt_d;
  logic last_q, last_d, err_q, err_d, locked, win1;
`ifdef TXARB_LOCK_EN
  assign locked = |(grant_q & {lock1, lock0});
`else
  logic unused_lock;
  assign unused_lock = lock0 ^ lock1;
  assign locked = 1'b0;
`endif
  assign elig = locked ? ({req1, req0} & grant_q) : {req1, req0};
  assign win1 = elig[1] & (~elig[0] | ~last_q);
  assign tx_start = state_q == START;
  assign ack0 = tx_start & grant_q[0];
  assign ack1 = tx_start & grant_q[1];
  assign tx_data = tx_data_q;
  assign grant = grant_q;
  assign err = err_q;
  // next state: select a winner, pulse start, watch tx_ready fall then rise
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    tx_data_d = tx_data_q;
    cnt_d = cnt_q;
    last_d = last_q;
    err_d = err_q;
    case (state_q)
      IDLE: begin
        grant_d = locked ? grant_q : 2'b00;
        if (tx_ready && elig != 2'b00) begin
          grant_d = win1 ? 2'b10 : 2'b01;
          tx_data_d = win1 ? data1 : data0;
          state_d = START;
        end
      end
      START: begin
        cnt_d = 8'd0;
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!tx_ready) state_d = WAIT_HIGH;
        else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT) begin
            err_d = 1'b1;
            grant_d = 2'b00;
            state_d = IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        if (tx_ready) begin
          last_d = grant_q[1];
          grant_d = locked ? grant_q : 2'b00;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state register; last starts at 1 so port 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      tx_data_q <= 8'h00;
      cnt_q <= 8'd0;
      last_q <= 1'b1;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      tx_data_q <= tx_data_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_simplez_tx_arbiter.sv
// tb_simplez_tx_arbiter: vector table plus scoreboard bench for simplez_tx_arbiter
module tb_simplez_tx_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic ack0, ack1, tx_start, err, tx_ready;
  logic [7:0] tx_data;
  logic [1:0] grant;
  logic tx_ready_m = 1'b1, dead = 1'b0, hold_low = 1'b0;
  int busy_cnt = 0, total = 0, bad = 0, n_start = 0;
  typedef struct packed {logic port; logic [7:0] data;} exp_t;
  typedef struct packed {logic r0; logic r1; logic [7:0] d0; logic [7:0] d1; logic port; logic [7:0] exp;} vec_t;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[8];

  simplez_tx_arbiter #(.START_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1), .lock0(lock0), .lock1(lock1),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data), .grant(grant), .err(err)
  );

  always #5 clk = ~clk;

  // transmitter model: busy 10 cycles per accepted start; dead ignores starts
  always @(posedge clk) begin
    if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) tx_ready_m <= 1'b1;
    end else if (tx_start && !dead) begin
      busy_cnt <= 10;
      tx_ready_m <= 1'b0;
    end
  end
  assign tx_ready = tx_ready_m & ~hold_low;

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  // scoreboard: every start must match the oldest expected byte and owner
  always @(negedge clk) begin
    if (tx_start) begin
      n_start++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: tx_start with data %h, nothing expected", tx_data);
      end else begin
        mon_e = sb.pop_front();
        check("sb_data", int'(tx_data), int'(mon_e.data));
        check("sb_grant", int'(grant), mon_e.port ? 2 : 1);
        check("sb_ack", int'({ack1, ack0}), mon_e.port ? 2 : 1);
      end
    end
  end

  task automatic wait_start(output int lat);
    lat = 0;
    while (!tx_start && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic settle();
    int c;
    c = 0;
    repeat (2) @(negedge clk);
    while (!(tx_ready && busy_cnt == 0) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("settle", int'(c < 200), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, n, c, rise;
    logic prev;
    vecs[0] = {1'b1, 1'b0, 8'h41, 8'h00, 1'b0, 8'h41};
    vecs[1] = {1'b1, 1'b1, 8'ha1, 8'hb2, 1'b1, 8'hb2};
    vecs[2] = {1'b1, 1'b1, 8'hc3, 8'hd4, 1'b0, 8'hc3};
    vecs[3] = {1'b0, 1'b1, 8'h00, 8'he5, 1'b1, 8'he5};
    vecs[4] = {1'b0, 1'b1, 8'h00, 8'h66, 1'b1, 8'h66};
    vecs[5] = {1'b1, 1'b1, 8'h77, 8'h88, 1'b0, 8'h77};
    vecs[6] = {1'b1, 1'b1, 8'h99, 8'haa, 1'b1, 8'haa};
    vecs[7] = {1'b1, 1'b0, 8'h5a, 8'h00, 1'b0, 8'h5a};
    repeat (2) @(negedge clk);
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_ack", int'({ack1, ack0}), 0);
    check("rst_grant", int'(grant), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    @(negedge clk);
    // continuous tie after reset: 10,20,10,20 with 2-cycle ready-to-start gap
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h10; data1 = 8'h20;
    sb.push_back({1'b0, 8'h10}); sb.push_back({1'b1, 8'h20});
    sb.push_back({1'b0, 8'h10}); sb.push_back({1'b1, 8'h20});
    n = 0; rise = -100; prev = tx_ready;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clk);
      if (tx_ready && !prev) rise = i;
      prev = tx_ready;
      if (tx_start) begin
        if (n > 0) check("b2b_gap", i - rise, 2);
        n++;
      end
    end
    check("tie_count", n, 4);
    req0 = 1'b0; req1 = 1'b0;
    settle();
    // table of single-byte transfers covering round-robin history
    for (int i = 0; i < 8; i++) begin
      req0 = vecs[i].r0; req1 = vecs[i].r1; data0 = vecs[i].d0; data1 = vecs[i].d1;
      sb.push_back({vecs[i].port, vecs[i].exp});
      wait_start(lat);
      check("vec_latency", lat, 1);
      req0 = 1'b0; req1 = 1'b0;
      settle();
    end
    // transmitter busy: no start until tx_ready returns
    hold_low = 1'b1; req1 = 1'b1; data1 = 8'h33;
    sb.push_back({1'b1, 8'h33});
    n = n_start;
    repeat (30) @(negedge clk);
    check("busy_nostart", n_start - n, 0);
    check("busy_grant", int'(grant), 0);
    hold_low = 1'b0;
    wait_start(lat);
    check("busy_release_lat", lat, 1);
    req1 = 1'b0;
    settle();
`ifdef TXARB_LOCK_EN
    req1 = 1'b1; lock1 = 1'b1; data1 = 8'h71; data0 = 8'h70;
    repeat (3) sb.push_back({1'b1, 8'h71});
    sb.push_back({1'b0, 8'h70});
    n = 0;
    for (int i = 0; i < 300 && n < 4; i++) begin
      @(negedge clk);
      if (tx_start) begin
        n++;
        if (n == 1) req0 = 1'b1;
        if (n == 3) begin req1 = 1'b0; lock1 = 1'b0; end
        if (n == 4) req0 = 1'b0;
      end
    end
    check("lock_count", n, 4);
    settle();
`endif
    // dead transmitter: err 17 cycles after the start, sticky
    dead = 1'b1; req0 = 1'b1; data0 = 8'h3c;
    sb.push_back({1'b0, 8'h3c});
    wait_start(lat);
    check("dead_latency", lat, 1);
    req0 = 1'b0;
    c = 0;
    while (!err && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("err_delay", c, 17);
    check("err_grant", int'(grant), 0);
    repeat (20) @(negedge clk);
    check("err_sticky", int'(err), 1);
    dead = 1'b0;
    settle();
    // async reset while waiting for tx_ready to rise
    req1 = 1'b1; data1 = 8'h5e;
    sb.push_back({1'b1, 8'h5e});
    wait_start(lat);
    check("pre_rst_lat", lat, 1);
    req1 = 1'b0;
    c = 0;
    while (tx_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    check("pre_rst_grant", int'(grant), 2);
    #2 rst = 1'b1;
    #1;
    check("arst_grant", int'(grant), 0);
    check("arst_tx_start", int'(tx_start), 0);
    check("arst_err", int'(err), 0);
    check("arst_tx_data", int'(tx_data), 0);
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h61; data1 = 8'h62;
    sb.push_back({1'b0, 8'h61});
    wait_start(lat);
    check("post_rst_seen", int'(lat < 200), 1);
    req0 = 1'b0; req1 = 1'b0;
    settle();
    check("sb_leftover", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
